fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch front end that drives the IF/ID pipeline register: it owns the fetch PC, runs a single-outstanding request/response handshake with instruction memory, holds a returned instruction while the pipeline stalls, and redirects on a taken branch/jump from Execute. Its InstrF/PCF outputs feed the decode pipeline register directly; when no instruction is ready it presents a NOP bubble.

## Interface
- RESET_PC, 32'h0040_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction presented when no valid fetch (addi x0,x0,0)
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- StallF  in  1  hazard unit: hold current instruction, do not advance PC
- BranchTakenE  in  1  redirect request from Execute
- PCTargetE  in  32  redirect target
- IMemReq  out  1  request valid
- IMemAddr  out  32  request address (word aligned)
- IMemReady  in  1  memory accepts request this cycle (IMemReq & IMemReady = accept)
- IMemRValid  in  1  response valid (exactly one per accepted request, earliest the cycle after accept)
- IMemRData  in  32  response instruction
- InstrF  out  32  instruction to IF/ID register
- PCF  out  32  PC of InstrF
- FetchValidF  out  1  InstrF/PCF carry a real instruction this cycle

## Operation
- State: pc_q (32), hold_q (32 instruction buffer), state ∈ {S_REQ, S_WAIT, S_KILL, S_HOLD}.
- S_REQ: IMemReq=1, IMemAddr=pc_q. On accept → S_WAIT. IMemRValid ignored.
- S_WAIT: on IMemRValid: if StallF, hold_q<=IMemRData, → S_HOLD; else deliver IMemRData, pc_q<=pc_q+4, → S_REQ.
- S_HOLD: deliver hold_q; when ~StallF, pc_q<=pc_q+4, → S_REQ.
- S_KILL: outstanding response is discarded; on IMemRValid → S_REQ.
- Redirect (BranchTakenE) has priority over StallF and delivery in every state; pc_q<=PCTargetE, nothing delivered that cycle. Next state: S_REQ with accept same cycle → S_KILL; S_REQ without accept → S_REQ (new address next cycle); S_WAIT without IMemRValid → S_KILL; S_WAIT with IMemRValid → S_REQ (response dropped); S_HOLD → S_REQ (hold_q dropped); S_KILL → S_KILL, or S_REQ if IMemRValid same cycle.
- Delivery (combinational): FetchValidF = ~RESET & ~BranchTakenE & ((S_WAIT & IMemRValid) | S_HOLD). When valid: InstrF = response or hold_q, PCF = pc_q. When invalid: InstrF = NOP_INSTR, PCF = 0.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC+4 = 0). PCTargetE[1:0] is forced to 0 when loaded.
- IMemAddr is held stable while IMemReq=1 and not accepted, unless a redirect changes pc_q.

## Timing
- Reset: state=S_REQ, pc_q=RESET_PC, hold_q=NOP_INSTR. While RESET high: IMemReq=0, FetchValidF=0, InstrF=NOP_INSTR, PCF=0, IMemAddr=RESET_PC. First request is presented in the first cycle after RESET deasserts.
- RESET mid-transaction abandons the in-flight request; instruction memory shares RESET and drops it too.
- Minimum latency request→delivery: 2 cycles (accept in cycle N, response and delivery in N+1). Peak throughput: one instruction per 2 cycles.
- StallF asserted at the response cycle: instruction held in hold_q with FetchValidF=1 every stalled cycle; PC advances on the first unstalled cycle.
- Redirect latency: target address appears on IMemAddr the cycle after BranchTakenE, or after the killed response returns.

## Structure
- Shared core package: fetch state enum (S_REQ, S_WAIT, S_KILL, S_HOLD), NOP_INSTR constant, default RESET_PC.
- One sub-module: fetch_hold_buffer (32-bit load/clear holding register with valid flag).
- FSM, PC register and output muxing stay in fetch_stage.

## Test plan
- Reset then 1-cycle memory, always ready, no stall -> requests 0x00400000, 0x00400004, 0x00400008; each delivered one cycle after accept, FetchValidF pulses every other cycle, NOP on gaps.
- IMemReady low 3 cycles on 0x00400000 -> IMemAddr stable 3 cycles, single accept, PC advances exactly once.
- StallF high 4 cycles spanning response 0x00A00093 -> InstrF=0x00A00093, PCF=0x00400000, FetchValidF=1 all 4 cycles; next request 0x00400004 the cycle after StallF drops.
- BranchTakenE with PCTargetE=0x00400100 while S_WAIT, response 2 cycles later -> response discarded (FetchValidF=0), next request 0x00400100.
- Redirect in same cycle as accept, then second redirect to 0x00400200 while S_KILL -> killed response dropped, next request 0x00400200.
- RESET asserted while S_HOLD -> FetchValidF=0, InstrF=0x00000013, IMemReq=0; after release request 0x00400000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM states, the NOP
// bubble encoding and the default boot address.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// Holding register for an instruction returned while decode is stalled.
// Clear wins over load; an empty buffer always reads back as a NOP.
module fetch_hold_buffer
    import fetch_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data_in,
    output logic [31:0] data,
    output logic        valid
);

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            data  <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the fetch PC, keeps one request outstanding to
// instruction memory, buffers a response across stalls and handles redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        StallF,
    input  logic        BranchTakenE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRValid,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic        FetchValidF
);

    fetch_state_e state, state_next;
    logic [31:0]  pc_q, pc_next;
    logic [31:0]  hold_data;
    logic         hold_valid, hold_load, hold_clear;
    logic         accept, advance;

    assign accept = IMemReq & IMemReady;

    fetch_hold_buffer u_hold (
        .CLK     (CLK),
        .RESET   (RESET),
        .load    (hold_load),
        .clear   (hold_clear),
        .data_in (IMemRData),
        .data    (hold_data),
        .valid   (hold_valid)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    // A redirect never delivers, so an in-flight response must be killed
    // unless it is returning in the very same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            S_REQ: begin
                if (BranchTakenE) begin
                    state_next = accept ? S_KILL : S_REQ;
                end else if (accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (IMemRValid) begin
                    state_next = (StallF && !BranchTakenE) ? S_HOLD : S_REQ;
                end else if (BranchTakenE) begin
                    state_next = S_KILL;
                end
            end
            S_HOLD: begin
                if (BranchTakenE || !StallF) begin
                    state_next = S_REQ;
                end
            end
            S_KILL: begin
                if (IMemRValid) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        advance    = !BranchTakenE && !StallF &&
                     ((state == S_WAIT && IMemRValid) || state == S_HOLD);
        hold_load  = !BranchTakenE && StallF && state == S_WAIT && IMemRValid;
        hold_clear = state == S_HOLD && (BranchTakenE || !StallF);
        pc_next    = pc_q;
        if (BranchTakenE) begin
            pc_next = align_word(PCTargetE);
        end else if (advance) begin
            pc_next = pc_q + 32'd4;
        end
    end

    always_comb begin
        IMemReq     = !RESET && state == S_REQ;
        IMemAddr    = RESET ? RESET_PC : pc_q;
        FetchValidF = !RESET && !BranchTakenE &&
                      ((state == S_WAIT && IMemRValid) || (state == S_HOLD && hold_valid));
        InstrF      = NOP_INSTR;
        PCF         = 32'd0;
        if (FetchValidF) begin
            InstrF = (state == S_HOLD) ? hold_data : IMemRData;
            PCF    = pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a single-outstanding memory model plus a
// transaction-level reference of the fetch front end.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET, StallF, BranchTakenE, IMemReady, IMemRValid;
    logic [31:0] PCTargetE, IMemRData;
    logic        IMemReq, FetchValidF;
    logic [31:0] IMemAddr, InstrF, PCF;

    always #5 CLK = ~CLK;

    fetch_stage dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .StallF       (StallF),
        .BranchTakenE (BranchTakenE),
        .PCTargetE    (PCTargetE),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemReady    (IMemReady),
        .IMemRValid   (IMemRValid),
        .IMemRData    (IMemRData),
        .InstrF       (InstrF),
        .PCF          (PCF),
        .FetchValidF  (FetchValidF)
    );

    int errors = 0;
    int checks = 0;

    // Instruction memory: one transaction at a time, response after mem_cnt cycles.
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          fixed_lat = 1;
    bit          rand_lat;
    bit          force_en;
    logic [31:0] force_word;

    // Reference: fetch PC, outstanding request (possibly killed), held instruction.
    logic [31:0] m_pc, m_hinstr;
    bit          m_out, m_kill, m_held;

    logic        exp_req;
    logic [97:0] expv, obsv;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return force_en ? force_word : ({a[31:2], 2'b11} ^ 32'h0A5A_0000);
    endfunction

    task automatic drive(input bit rst, input bit st, input bit br,
                         input logic [31:0] tgt, input bit rdy);
        logic        e_valid;
        logic [31:0] e_instr, e_pc;
        RESET        = rst;
        StallF       = st;
        BranchTakenE = br;
        PCTargetE    = tgt;
        IMemReady    = rdy;
        IMemRValid   = !rst && mem_busy && mem_cnt == 1;
        IMemRData    = IMemRValid ? mem_word(mem_addr) : $urandom;
        #1;
        if (rst) begin
            exp_req = 1'b0;
            expv    = {1'b0, RST_PC, 1'b0, NOP, 32'd0};
        end else begin
            exp_req = !m_out && !m_held;
            e_valid = !br && ((m_out && !m_kill && IMemRValid) || m_held);
            e_instr = !e_valid ? NOP : (m_held ? m_hinstr : IMemRData);
            e_pc    = e_valid ? m_pc : 32'd0;
            expv    = {exp_req, m_pc, e_valid, e_instr, e_pc};
        end
        obsv = {IMemReq, IMemAddr, FetchValidF, InstrF, PCF};
    endtask

    task automatic tick();
        if (RESET) begin
            mem_busy = 0;
        end else begin
            if (IMemRValid) mem_busy = 0;
            else if (mem_busy) mem_cnt--;
            if (IMemReq && IMemReady) begin
                mem_busy = 1;
                mem_cnt  = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
                mem_addr = IMemAddr;
            end
        end
        if (RESET) begin
            m_pc = RST_PC; m_out = 0; m_kill = 0; m_held = 0; m_hinstr = NOP;
        end else if (BranchTakenE) begin
            m_pc   = {PCTargetE[31:2], 2'b00};
            m_held = 0;
            if (m_out) begin
                if (IMemRValid) begin m_out = 0; m_kill = 0; end
                else m_kill = 1;
            end else if (exp_req && IMemReady) begin
                m_out = 1; m_kill = 1;
            end
        end else if (m_out && IMemRValid) begin
            if (m_kill) begin
                m_out = 0; m_kill = 0;
            end else if (StallF) begin
                m_held = 1; m_hinstr = IMemRData; m_out = 0;
            end else begin
                m_pc = m_pc + 32'd4; m_out = 0;
            end
        end else if (m_held && !StallF) begin
            m_held = 0; m_pc = m_pc + 32'd4;
        end else if (exp_req && IMemReady) begin
            m_out = 1; m_kill = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 32'd0, 0);
        tick();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, c[0], 1, 32'h1234_5678, 1);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL reset c=%0d got=%h want=%h", c, obsv, expv);
            end
            checks++;
            if ({IMemReq, FetchValidF, InstrF, IMemAddr} !== {1'b0, 1'b0, NOP, RST_PC}) begin
                errors++; $display("FAIL reset_outputs c=%0d got=%b/%b/%h/%h", c, IMemReq, FetchValidF, InstrF, IMemAddr);
            end
            tick();
        end
    endtask

    task automatic test_streaming();
        fixed_lat = 1; rand_lat = 0; force_en = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 32'd0, 1);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL stream c=%0d got=%h want=%h", c, obsv, expv);
            end
            checks++;
            if (c % 2 == 0) begin
                if ({IMemReq, IMemAddr, FetchValidF, InstrF} !== {1'b1, RST_PC + 32'(4 * (c / 2)), 1'b0, NOP}) begin
                    errors++; $display("FAIL stream_req c=%0d got=%b %h %b", c, IMemReq, IMemAddr, FetchValidF);
                end
            end else begin
                if ({IMemReq, FetchValidF, PCF} !== {1'b0, 1'b1, RST_PC + 32'(4 * (c / 2))}) begin
                    errors++; $display("FAIL stream_dlv c=%0d got=%b %b %h", c, IMemReq, FetchValidF, PCF);
                end
            end
            tick();
        end
    endtask

    task automatic test_ready_low();
        fixed_lat = 1; rand_lat = 0; force_en = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 32'd0, c >= 3);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL ready_low c=%0d got=%h want=%h", c, obsv, expv);
            end
            if (c < 4 || c == 5) begin
                checks++;
                if ({IMemReq, IMemAddr} !== {1'b1, (c == 5) ? RST_PC + 32'd4 : RST_PC}) begin
                    errors++; $display("FAIL ready_low_addr c=%0d got=%b %h", c, IMemReq, IMemAddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        fixed_lat = 1; rand_lat = 0; force_en = 1; force_word = 32'h00A0_0093;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(0, c >= 1 && c <= 4, 0, 32'd0, 1);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL stall c=%0d got=%h want=%h", c, obsv, expv);
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({FetchValidF, InstrF, PCF, IMemReq} !== {1'b1, 32'h00A0_0093, RST_PC, 1'b0}) begin
                    errors++; $display("FAIL stall_hold c=%0d got=%b %h %h", c, FetchValidF, InstrF, PCF);
                end
            end
            if (c == 6) begin
                checks++;
                if ({IMemReq, IMemAddr} !== {1'b1, RST_PC + 32'd4}) begin
                    errors++; $display("FAIL stall_next got=%b %h want 1 00400004", IMemReq, IMemAddr);
                end
            end
            tick();
        end
        force_en = 0;
    endtask

    task automatic test_redirect_wait();
        fixed_lat = 2; rand_lat = 0; force_en = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, c == 1, 32'h0040_0100, 1);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL redir_wait c=%0d got=%h want=%h", c, obsv, expv);
            end
            if (c == 2) begin
                checks++;
                if ({IMemRValid, FetchValidF, InstrF} !== {1'b1, 1'b0, NOP}) begin
                    errors++; $display("FAIL redir_wait_drop got rv=%b v=%b %h", IMemRValid, FetchValidF, InstrF);
                end
            end
            if (c == 3) begin
                checks++;
                if ({IMemReq, IMemAddr} !== {1'b1, 32'h0040_0100}) begin
                    errors++; $display("FAIL redir_wait_addr got=%b %h want 1 00400100", IMemReq, IMemAddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_redirect_kill();
        fixed_lat = 3; rand_lat = 0; force_en = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, c <= 1, (c == 0) ? 32'h0040_0100 : 32'h0040_0200, 1);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL redir_kill c=%0d got=%h want=%h", c, obsv, expv);
            end
            if (c == 3) begin
                checks++;
                if ({IMemRValid, FetchValidF} !== 2'b10) begin
                    errors++; $display("FAIL redir_kill_drop got rv=%b v=%b", IMemRValid, FetchValidF);
                end
            end
            if (c == 4) begin
                checks++;
                if ({IMemReq, IMemAddr} !== {1'b1, 32'h0040_0200}) begin
                    errors++; $display("FAIL redir_kill_addr got=%b %h want 1 00400200", IMemReq, IMemAddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_in_hold();
        fixed_lat = 1; rand_lat = 0; force_en = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(c == 3, c >= 1, 0, 32'd0, 1);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL rst_hold c=%0d got=%h want=%h", c, obsv, expv);
            end
            if (c == 3) begin
                checks++;
                if ({FetchValidF, InstrF, IMemReq} !== {1'b0, NOP, 1'b0}) begin
                    errors++; $display("FAIL rst_hold_out got=%b %h %b", FetchValidF, InstrF, IMemReq);
                end
            end
            if (c == 4) begin
                checks++;
                if ({IMemReq, IMemAddr} !== {1'b1, RST_PC}) begin
                    errors++; $display("FAIL rst_hold_req got=%b %h want 1 00400000", IMemReq, IMemAddr);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        fixed_lat = 1; rand_lat = 0; force_en = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, c == 0, 32'hFFFF_FFFF, c != 0);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL wrap c=%0d got=%h want=%h", c, obsv, expv);
            end
            checks++;
            if ((c == 1 && IMemAddr !== 32'hFFFF_FFFC) ||
                (c == 2 && {FetchValidF, PCF} !== {1'b1, 32'hFFFF_FFFC}) ||
                (c == 3 && {IMemReq, IMemAddr} !== {1'b1, 32'd0})) begin
                errors++; $display("FAIL wrap_pc c=%0d got addr=%h pcf=%h v=%b", c, IMemAddr, PCF, FetchValidF);
            end
            tick();
        end
    endtask

    task automatic test_random();
        rand_lat = 1; force_en = 0;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0, $urandom, $urandom_range(0, 4) < 3);
            checks++;
            if (obsv !== expv) begin
                errors++; $display("FAIL random c=%0d got=%h want=%h", c, obsv, expv);
            end
            tick();
        end
        rand_lat = 0;
    endtask

    initial begin
        RESET = 1; StallF = 0; BranchTakenE = 0; PCTargetE = 0;
        IMemReady = 0; IMemRValid = 0; IMemRData = 0;
        mem_busy = 0; mem_cnt = 0; mem_addr = 0; rand_lat = 0; force_en = 0; force_word = 0;
        m_pc = RST_PC; m_hinstr = NOP; m_out = 0; m_kill = 0; m_held = 0;
        exp_req = 0; expv = 0; obsv = 0;
        @(posedge CLK);
        #1;
        test_reset();
        test_streaming();
        test_ready_low();
        test_stall();
        test_redirect_wait();
        test_redirect_kill();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
